// File: rtl/lti_seq_system.sv
// lti_seq_system
// SISO delta-operator state-space filter built around one shared multiplier.
//   x <- sat(x + (A*x + B*u) >>> DEL),  y = sat((C*x + D*u) >>> CF)
// The coefficient matrix [[A B];[C D]] sits in a runtime-writable register
// file at address r*K+c.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ce_in, sig_in       sample strobe and signed input sample u
//   sig_out, ce_out     registered signed output y and its one-cycle strobe
//   busy                a sample is being computed
//   overrun             one-cycle pulse when a ce_in is dropped while busy
//   clear_state         synchronous state clear and abort
//   coef_we/addr/wdata  coefficient write port (ignored while busy)
module lti_seq_system #(
  parameter int NS  = 4,
  parameter int IW  = 16,
  parameter int OW  = 16,
  parameter int CW  = 16,
  parameter int SW  = 18,
  parameter int CF  = 15,
  parameter int DEL = 10,
  localparam int K   = NS + 1,
  localparam int AW  = $clog2(K * K),
  localparam int PW  = CW + SW,
  localparam int ACW = PW + $clog2(K),
  localparam int XW  = SW + CF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce_in,
  input  logic [IW-1:0] sig_in,
  output logic [OW-1:0] sig_out,
  output logic          ce_out,
  output logic          busy,
  output logic          overrun,
  input  logic          clear_state,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata
);
  localparam int KK   = K * K;
  localparam int RW   = $clog2(K);
  localparam int SUMW = ((XW > ACW) ? XW : ACW) + 1;
  localparam logic [XW-1:0] X_MAX = {1'b0, {(XW-1){1'b1}}};
  localparam logic [XW-1:0] X_MIN = {1'b1, {(XW-1){1'b0}}};
  localparam logic [OW-1:0] Y_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] Y_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_UPDATE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d, col_q, col_d;
  logic                 drain_q, drain_d;
  logic signed [SW-1:0] u_q, u_d;
  logic signed [SW-1:0] xs_q [NS];
  logic signed [SW-1:0] xs_d [NS];
  logic signed [CW-1:0] coef_q [KK];
  logic signed [CW-1:0] coef_d [KK];
  logic signed [XW-1:0] x_long_q [NS];
  logic signed [XW-1:0] x_long_d [NS];
  logic signed [ACW-1:0] dx_q [NS];
  logic signed [ACW-1:0] dx_d [NS];
  logic signed [ACW-1:0] y_acc_q, y_acc_d, acc_q, acc_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic                 pv_q, pv_d, plast_q, plast_d;
  logic [RW-1:0]        prow_q, prow_d;
  logic [OW-1:0]        sig_out_q, sig_out_d;
  logic                 ce_out_q, ce_out_d, overrun_q, overrun_d;

  logic [AW-1:0]         rd_addr;
  logic signed [CW-1:0]  coef_rd;
  logic signed [SW-1:0]  v_sel;
  logic signed [PW-1:0]  mult_full;
  logic signed [ACW-1:0] acc_sum;
  logic signed [ACW-1:0] y_shift;
  logic signed [SUMW-1:0] upd_sum;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    drain_d   = drain_q;
    u_d       = u_q;
    xs_d      = xs_q;
    coef_d    = coef_q;
    x_long_d  = x_long_q;
    dx_d      = dx_q;
    y_acc_d   = y_acc_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    pv_d      = 1'b0;
    plast_d   = plast_q;
    prow_d    = prow_q;
    sig_out_d = sig_out_q;
    ce_out_d  = 1'b0;
    overrun_d = ce_in && (state_q != ST_IDLE) && !clear_state;
    upd_sum   = '0;
    y_shift   = '0;

    // Operand fetch for the current issue slot; column NS selects u.
    rd_addr = AW'(int'(row_q) * K + int'(col_q));
    coef_rd = coef_q[rd_addr];
    v_sel   = u_q;
    for (int c = 0; c < NS; c++) begin
      if (col_q == RW'(c)) v_sel = xs_q[c];
    end
    mult_full = PW'(coef_rd) * PW'(v_sel);

    // Accumulate stage, one cycle behind the product register.
    acc_sum = acc_q + ACW'(prod_q);
    if (pv_q) begin
      if (plast_q) begin
        acc_d = '0;
        if (prow_q == RW'(NS)) y_acc_d = acc_sum;
        for (int i = 0; i < NS; i++) begin
          if (prow_q == RW'(i)) dx_d[i] = acc_sum;
        end
      end else begin
        acc_d = acc_sum;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ce_in && !clear_state) begin
          state_d = ST_MAC;
          row_d   = '0;
          col_d   = '0;
          u_d     = SW'($signed(sig_in));
          // Snapshot keeps the MAC on pre-update state for the whole sample.
          for (int i = 0; i < NS; i++) xs_d[i] = x_long_q[i][XW-1:CF];
        end
        if (coef_we && (int'(coef_addr) < KK)) coef_d[coef_addr] = coef_wdata;
      end
      ST_MAC: begin
        pv_d    = 1'b1;
        prod_d  = mult_full;
        prow_d  = row_q;
        plast_d = (col_q == RW'(NS));
        if (col_q == RW'(NS)) begin
          col_d = '0;
          if (row_q == RW'(NS)) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          // Results are committed on entry to UPDATE so ce_out is high in it.
          state_d  = ST_UPDATE;
          drain_d  = 1'b0;
          ce_out_d = 1'b1;
          for (int i = 0; i < NS; i++) begin
            upd_sum = SUMW'(x_long_q[i]) + SUMW'(dx_q[i] >>> DEL);
            if (upd_sum[SUMW-1:XW-1] != {(SUMW-XW+1){upd_sum[SUMW-1]}})
              x_long_d[i] = upd_sum[SUMW-1] ? X_MIN : X_MAX;
            else
              x_long_d[i] = upd_sum[XW-1:0];
          end
          y_shift = y_acc_q >>> CF;
          if (y_shift[ACW-1:OW-1] != {(ACW-OW+1){y_shift[ACW-1]}})
            sig_out_d = y_shift[ACW-1] ? Y_MIN : Y_MAX;
          else
            sig_out_d = y_shift[OW-1:0];
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Clear overrides everything above, including a commit in this cycle.
    if (clear_state) begin
      state_d   = ST_IDLE;
      row_d     = '0;
      col_d     = '0;
      drain_d   = 1'b0;
      pv_d      = 1'b0;
      acc_d     = '0;
      ce_out_d  = 1'b0;
      sig_out_d = sig_out_q;
      for (int i = 0; i < NS; i++) x_long_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      drain_q   <= 1'b0;
      u_q       <= '0;
      y_acc_q   <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      pv_q      <= 1'b0;
      plast_q   <= 1'b0;
      prow_q    <= '0;
      sig_out_q <= '0;
      ce_out_q  <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < KK; i++) coef_q[i] <= '0;
      for (int i = 0; i < NS; i++) begin
        xs_q[i]     <= '0;
        x_long_q[i] <= '0;
        dx_q[i]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      drain_q   <= drain_d;
      u_q       <= u_d;
      y_acc_q   <= y_acc_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      pv_q      <= pv_d;
      plast_q   <= plast_d;
      prow_q    <= prow_d;
      sig_out_q <= sig_out_d;
      ce_out_q  <= ce_out_d;
      overrun_q <= overrun_d;
      coef_q    <= coef_d;
      xs_q      <= xs_d;
      x_long_q  <= x_long_d;
      dx_q      <= dx_d;
    end
  end

  assign sig_out = sig_out_q;
  assign ce_out  = ce_out_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lti_seq_system.sv
// Testbench for lti_seq_system: directed scenarios plus randomized samples
// checked against a plain-arithmetic model of the state-space recurrence.
module tb_lti_seq_system;
  localparam int NS = 4;
  localparam int K  = NS + 1;
  localparam int KK = K * K;
  localparam int AW = $clog2(KK);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce_in = 1'b0;
  logic [15:0]   sig_in = '0;
  logic [15:0]   sig_out;
  logic          ce_out;
  logic          busy;
  logic          overrun;
  logic          clear_state = 1'b0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [15:0]   coef_wdata = '0;

  always #5 clk = ~clk;

  lti_seq_system dut (
    .clk(clk), .rst_n(rst_n), .ce_in(ce_in), .sig_in(sig_in),
    .sig_out(sig_out), .ce_out(ce_out), .busy(busy), .overrun(overrun),
    .clear_state(clear_state), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: coefficient matrix and full-precision states.
  longint mc [KK];
  longint mxl [NS];
  longint last_y;

  // Per-sample observations.
  int     n_ce, n_ov, n_busy, lat;
  longint y_got;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // y from pre-update state, then x <- sat(x + floor(dx / 2^10)).
  function automatic longint model_step(input longint u);
    longint v [K];
    longint dx [NS];
    longint acc, y;
    y = 0;
    for (int c = 0; c < NS; c++) v[c] = mxl[c] >>> 15;
    v[NS] = u;
    for (int r = 0; r < K; r++) begin
      acc = 0;
      for (int c = 0; c < K; c++) acc += mc[r*K + c] * v[c];
      if (r < NS) dx[r] = acc;
      else y = sat(acc >>> 15, 16);
    end
    for (int i = 0; i < NS; i++) mxl[i] = sat(mxl[i] + (dx[i] >>> 10), 33);
    return y;
  endfunction

  task automatic model_clear_state();
    for (int i = 0; i < NS; i++) mxl[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ce_in = 1'b0;
    clear_state = 1'b0;
    coef_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < KK; i++) mc[i] = 0;
    model_clear_state();
    last_y = 0;
  endtask

  task automatic write_coef(input int addr, input longint val);
    logic [15:0] w;
    w = 16'(val);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = AW'(addr);
    coef_wdata = w;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (addr < KK) mc[addr] = longint'($signed(w));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_state = 1'b1;
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    model_clear_state();
  endtask

  // Accepts one sample, then watches 40 cycles. Cycle c is the one after
  // edge T+c-1; optional extra ce_in / clear / coef write at the end of cycle c.
  task automatic run_sample(input longint u, input int extra_ce_at, input int clear_at,
                            input int we_at, input longint we_val);
    @(negedge clk);
    ce_in = 1'b1;
    sig_in = 16'(u);
    @(posedge clk);
    #1;
    ce_in = 1'b0;
    n_ce = 0; n_ov = 0; n_busy = 0; lat = 0; y_got = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) n_busy++;
      if (overrun) n_ov++;
      if (ce_out) begin
        n_ce++;
        if (lat == 0) begin
          lat = c;
          y_got = longint'($signed(sig_out));
        end
      end
      ce_in = (c == extra_ce_at);
      clear_state = (c == clear_at);
      coef_we = (c == we_at);
      coef_addr = AW'(24);
      coef_wdata = 16'(we_val);
      @(posedge clk);
      #1;
      ce_in = 1'b0;
      clear_state = 1'b0;
      coef_we = 1'b0;
    end
    $display("sample u=%0d -> y=%0d lat=%0d ce=%0d ovr=%0d busy=%0d", u, y_got, lat, n_ce, n_ov, n_busy);
  endtask

  task automatic normal_sample(input longint u, output longint y_exp);
    run_sample(u, 0, 0, 0, 0);
    y_exp = model_step(u);
    check_eq("ce_count", n_ce, 1);
    check_eq("latency", lat, 28);
    check_eq("y_model", y_got, y_exp);
    last_y = y_exp;
  endtask

  longint ye;
  logic signed [15:0] rnd;

  initial begin
    do_reset();
    #1;
    check_eq("rst_sig_out", longint'(sig_out), 0);
    check_eq("rst_ce_out", longint'(ce_out), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_overrun", longint'(overrun), 0);

    // Zero response.
    normal_sample(1000, ye);
    check_eq("zero_y", y_got, 0);
    check_eq("zero_busy_cycles", n_busy, 28);

    // Feedthrough D = 0.5.
    write_coef(24, 16384);
    normal_sample(1000, ye);
    check_eq("feed_y", y_got, 500);

    // Overrun: a second ce_in 5 cycles in is dropped.
    run_sample(1000, 5, 0, 0, 0);
    ye = model_step(1000);
    check_eq("ovr_pulses", n_ov, 1);
    check_eq("ovr_ce_count", n_ce, 1);
    check_eq("ovr_y", y_got, 500);
    last_y = ye;

    // Write lockout: writing D=0 while busy is ignored.
    run_sample(1000, 0, 0, 3, 0);
    ye = model_step(1000);
    check_eq("lock_y", y_got, 500);
    normal_sample(1000, ye);
    check_eq("lock_next_y", y_got, 500);

    // Abort at cycle 10.
    run_sample(1000, 0, 10, 0, 0);
    model_clear_state();
    check_eq("abort_ce_count", n_ce, 0);
    check_eq("abort_busy_cycles", n_busy, 10);
    check_eq("abort_sig_hold", longint'($signed(sig_out)), last_y);

    // ce_in together with clear_state: not accepted, no overrun.
    @(negedge clk);
    ce_in = 1'b1;
    clear_state = 1'b1;
    sig_in = 16'd1000;
    @(posedge clk);
    #1;
    ce_in = 1'b0;
    clear_state = 1'b0;
    model_clear_state();
    check_eq("ceclr_busy", longint'(busy), 0);
    check_eq("ceclr_overrun", longint'(overrun), 0);
    @(posedge clk);
    #1;
    check_eq("ceclr_overrun2", longint'(overrun), 0);

    // State path.
    do_reset();
    write_coef(4, 32767);
    write_coef(20, 32767);
    normal_sample(32767, ye);
    check_eq("state_y1", y_got, 0);
    check_eq("state_x0", longint'(dut.x_long_q[0]), 1048512);
    normal_sample(32767, ye);
    check_eq("state_y2", y_got, 30);
    pulse_clear();
    normal_sample(32767, ye);
    check_eq("state_after_clear", y_got, 0);

    // Output saturation.
    do_reset();
    write_coef(24, -32768);
    normal_sample(-32768, ye);
    check_eq("sat_y", y_got, 32767);

    // Reset mid-sample.
    @(negedge clk);
    ce_in = 1'b1;
    sig_in = 16'd1000;
    @(posedge clk);
    #1;
    ce_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", longint'(busy), 0);
    check_eq("midrst_sig_out", longint'(sig_out), 0);
    do_reset();

    // Randomized coefficients and samples.
    for (int a = 0; a < KK; a++) begin
      rnd = 16'($urandom);
      write_coef(a, longint'(rnd));
    end
    rnd = 16'($urandom);
    write_coef(KK + int'($urandom_range(0, 31 - KK)), longint'(rnd));
    for (int s = 0; s < 16; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        rnd = 16'($urandom);
        write_coef(int'($urandom_range(0, KK - 1)), longint'(rnd));
      end
      rnd = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        run_sample(longint'(rnd), 0, 0, int'($urandom_range(1, 27)), longint'(16'($urandom)));
        ye = model_step(longint'(rnd));
        check_eq("rnd_lock_ce", n_ce, 1);
        check_eq("rnd_lock_y", y_got, ye);
        last_y = ye;
      end else begin
        normal_sample(longint'(rnd), ye);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
